// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for an spi_master: TX FIFO feeding a one-byte-per-transaction
// launch FSM, with each received byte captured into a first-word fall-through RX FIFO.
module spi_byte_sequencer #(
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      spi_start,
  output logic [7:0]                spi_tx_data,
  input  logic                      spi_busy,
  input  logic [7:0]                spi_rx_data,
  input  logic                      spi_rx_valid,
  output logic                      seq_busy,
  output logic                      err_timeout
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 2);
  localparam logic [TAW:0]   TX_FULL  = (TAW + 1)'(TX_DEPTH);
  localparam logic [TAW:0]   TX_EMPTY = (TAW + 1)'(0);
  localparam logic [RAW:0]   RX_FULL  = (RAW + 1)'(RX_DEPTH);
  localparam logic [RAW:0]   RX_EMPTY = (RAW + 1)'(0);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
  // GAP_CYCLES of 0 and 1 both leave GAP on the first cycle spi_busy is seen low
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_RX   = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [7:0]     tx_mem_r [TX_DEPTH];
  logic [7:0]     rx_mem_r [RX_DEPTH];
  logic [TAW-1:0] tx_wr_r, tx_rd_r;
  logic [RAW-1:0] rx_wr_r, rx_rd_r;
  logic [TAW:0]   tx_level_r;
  logic [RAW:0]   rx_level_r;
  logic [2:0]     state_r, state_nxt_s;
  logic [7:0]     spi_tx_data_r;
  logic [TOW-1:0] to_cnt_r;
  logic [GCW-1:0] gap_cnt_r;
  logic           err_r;
  logic           tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, launch_s, timeout_s;

  // Output decode from registered state
  always_comb begin
    in_ready    = (tx_level_r != TX_FULL);
    out_valid   = (rx_level_r != RX_EMPTY);
    if (out_valid) out_data = rx_mem_r[rx_rd_r];
    else           out_data = 8'd0;
    tx_level    = tx_level_r;
    rx_level    = rx_level_r;
    spi_start   = (state_r == S_LAUNCH);
    spi_tx_data = spi_tx_data_r;
    seq_busy    = (state_r != S_IDLE);
    err_timeout = err_r;
  end

  // FIFO handshakes; clear overrides every push and pop
  always_comb begin
    launch_s  = (state_r == S_IDLE) && (tx_level_r != TX_EMPTY) && (rx_level_r < RX_FULL) && !clear;
    tx_push_s = in_valid && in_ready && !clear;
    tx_pop_s  = launch_s;
    rx_push_s = (state_r == S_WAIT_RX) && spi_rx_valid && !clear;
    rx_pop_s  = out_valid && out_ready && !clear;
  end

  // Next-state and timeout decode
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    if (clear) begin
      // Let an active spi_master transaction run out before relaunching
      state_nxt_s = spi_busy ? S_GAP : S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (launch_s) state_nxt_s = S_LAUNCH;
          else          state_nxt_s = S_IDLE;
        end
        S_LAUNCH: state_nxt_s = S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (spi_busy) begin
            state_nxt_s = S_WAIT_RX;
          end else if (to_cnt_r == TO_LAST) begin
            state_nxt_s = S_GAP;
            timeout_s   = 1'b1;
          end else begin
            state_nxt_s = S_WAIT_BUSY;
          end
        end
        S_WAIT_RX: begin
          if (spi_rx_valid) begin
            state_nxt_s = S_GAP;
          end else if (to_cnt_r == TO_LAST) begin
            state_nxt_s = S_GAP;
            timeout_s   = 1'b1;
          end else begin
            state_nxt_s = S_WAIT_RX;
          end
        end
        S_GAP: begin
          if (!spi_busy && (gap_cnt_r >= GAP_LAST)) state_nxt_s = S_IDLE;
          else                                      state_nxt_s = S_GAP;
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // FSM state, launched byte, wait/gap counters and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      spi_tx_data_r <= 8'd0;
      to_cnt_r      <= '0;
      gap_cnt_r     <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (launch_s) spi_tx_data_r <= tx_mem_r[tx_rd_r];
      if ((state_nxt_s == state_r) && ((state_r == S_WAIT_BUSY) || (state_r == S_WAIT_RX)))
        to_cnt_r <= to_cnt_r + TOW'(1);
      else
        to_cnt_r <= '0;
      if ((state_r == S_GAP) && (state_nxt_s == S_GAP) && !spi_busy)
        gap_cnt_r <= gap_cnt_r + GCW'(1);
      else
        gap_cnt_r <= '0;
      if (clear)          err_r <= 1'b0;
      else if (timeout_s) err_r <= 1'b1;
    end
  end

  // FIFO storage write ports
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_r] <= in_data;
    if (rx_push_s) rx_mem_r[rx_wr_r] <= spi_rx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_r    <= '0;
      tx_rd_r    <= '0;
      tx_level_r <= TX_EMPTY;
    end else if (clear) begin
      tx_wr_r    <= '0;
      tx_rd_r    <= '0;
      tx_level_r <= TX_EMPTY;
    end else begin
      if (tx_push_s) tx_wr_r <= tx_wr_r + TAW'(1);
      if (tx_pop_s)  tx_rd_r <= tx_rd_r + TAW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_level_r <= tx_level_r + (TAW + 1)'(1);
        2'b01:   tx_level_r <= tx_level_r - (TAW + 1)'(1);
        default: tx_level_r <= tx_level_r;
      endcase
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_r    <= '0;
      rx_rd_r    <= '0;
      rx_level_r <= RX_EMPTY;
    end else if (clear) begin
      rx_wr_r    <= '0;
      rx_rd_r    <= '0;
      rx_level_r <= RX_EMPTY;
    end else begin
      if (rx_push_s) rx_wr_r <= rx_wr_r + RAW'(1);
      if (rx_pop_s)  rx_rd_r <= rx_rd_r + RAW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_level_r <= rx_level_r + (RAW + 1)'(1);
        2'b01:   rx_level_r <= rx_level_r - (RAW + 1)'(1);
        default: rx_level_r <= rx_level_r;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a byte-level loopback spi_master model
// (busy rises the cycle after start, reply echoes the launched byte).
module tb_spi_byte_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear, in_valid, out_ready, spi_busy, spi_rx_valid;
  logic [7:0] in_data, spi_rx_data;
  logic       in_ready, out_valid, spi_start, seq_busy, err_timeout;
  logic [7:0] out_data, spi_tx_data;
  logic [4:0] tx_level, rx_level;

  int errors = 0, checks = 0;
  int cyc = 0;
  int start_cnt = 0, last_start = 0, prev_start = 0;
  int fall_cyc = 0, rxv_cyc = 0;
  int busy_len = 6;
  bit stuck = 1'b0;

  spi_byte_sequencer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tx_level(tx_level), .rx_level(rx_level),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .seq_busy(seq_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Start-pulse monitor
  initial forever begin
    @(negedge clk);
    if (spi_start) begin
      start_cnt  = start_cnt + 1;
      prev_start = last_start;
      last_start = cyc;
    end
  end

  // Loopback spi_master: a value set at a negedge stands for that whole cycle
  initial begin : spi_model
    logic [7:0] b;
    spi_busy = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 8'd0;
    forever begin
      @(negedge clk);
      if (spi_start && !stuck) begin
        b = spi_tx_data;
        @(negedge clk); spi_busy = 1'b1;
        repeat (busy_len - 1) @(negedge clk);
        spi_rx_data = b; spi_rx_valid = 1'b1; rxv_cyc = cyc;
        @(negedge clk);
        spi_rx_valid = 1'b0; spi_busy = 1'b0; fall_cyc = cyc;
      end
    end
  end

  task automatic wait_out_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL reset_tx_level: got %0d want 0", tx_level); end
    checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL reset_rx_level: got %0d want 0", rx_level); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b want 0", spi_start); end
    checks++; if (spi_tx_data !== 8'h00) begin errors++; $display("FAIL reset_spi_tx_data: got %h want 00", spi_tx_data); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL reset_seq_busy: got %b want 0", seq_busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int s0, k; bit ok;
    s0 = start_cnt;
    @(negedge clk); in_valid = 1'b1; in_data = 8'hA5; k = cyc;
    @(negedge clk); in_valid = 1'b0;
    wait_out_valid(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_wait: out_valid never rose"); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (last_start - k != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", last_start - k); end
    checks++; if (cyc - rxv_cyc != 1) begin errors++; $display("FAIL single_rx_latency: got %0d want 1", cyc - rxv_cyc); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data); end
    checks++; if (rx_level !== 5'd1) begin errors++; $display("FAIL single_rx_level: got %0d want 1", rx_level); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_timeout); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL single_pop_level: got %0d want 0", rx_level); end
  endtask

  task automatic test_fill();
    int s0, not_ready; bit ok;
    s0 = start_cnt; not_ready = 0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) not_ready++;
      in_valid = 1'b1; in_data = 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (not_ready != 0) begin errors++; $display("FAIL fill_in_ready: got %0d stalls want 0", not_ready); end
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = (rx_level == 5'd16); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_rx_full: got rx_level %0d want 16", rx_level); end
    in_valid = 1'b1; in_data = 8'h10;
    @(negedge clk); in_valid = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (start_cnt - s0 != 16) begin errors++; $display("FAIL fill_no_17th: got %0d starts want 16", start_cnt - s0); end
    checks++; if (tx_level !== 5'd1) begin errors++; $display("FAIL fill_tx_held: got %0d want 1", tx_level); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL fill_idle: got %b want 0", seq_busy); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, out_data, 8'(i)); end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    wait_out_valid(100, ok);
    checks++; if (!ok || out_data !== 8'h10) begin errors++; $display("FAIL fill_17th_reply: got valid %b data %h want 1 10", ok, out_data); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++; if (start_cnt - s0 != 17) begin errors++; $display("FAIL fill_17th_start: got %0d want 17", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    int s0, t0;
    stuck = 1'b1; s0 = start_cnt;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h40 + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL to_tx_full: got %0d want 16", tx_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_in_ready: got %b want 0", in_ready); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL to_first_start: got %0d want 1", start_cnt - s0); end
    t0 = last_start;
    while (cyc < t0 + 1000) @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", err_timeout); end
    while (cyc < t0 + 1030) @(negedge clk);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", err_timeout); end
    checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL to_no_push: got %0d want 0", rx_level); end
    checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL to_next_launch: got %0d want 2", start_cnt - s0); end
    checks++; if (tx_level !== 5'd15) begin errors++; $display("FAIL to_tx_level: got %0d want 15", tx_level); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL clr_tx_level: got %0d want 0", tx_level); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", err_timeout); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b want 0", seq_busy); end
    stuck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_gap();
    int s0; bit ok;
    s0 = start_cnt;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk); in_data = 8'hC3;
    @(negedge clk); in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = (start_cnt - s0 == 2); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_starts: got %0d want 2", start_cnt - s0); end
    checks++; if (last_start - fall_cyc != 3) begin errors++; $display("FAIL gap_after_fall: got %0d want 3", last_start - fall_cyc); end
    checks++; if (last_start - prev_start != 10) begin errors++; $display("FAIL gap_period: got %0d want 10", last_start - prev_start); end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = (rx_level == 5'd2); end
    checks++; if (!ok || out_data !== 8'h3C) begin errors++; $display("FAIL gap_data0: got level %0d data %h want 2 3c", rx_level, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 8'hC3) begin errors++; $display("FAIL gap_data1: got %h want c3", out_data); end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0; bit ok;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'(i + 1);
    end
    @(negedge clk); in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = (start_cnt - s0 == 3) && spi_busy; end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: got %0d starts want 3", start_cnt - s0); end
    checks++; if (tx_level !== 5'd2) begin errors++; $display("FAIL rst_mid_pre_tx: got %0d want 2", tx_level); end
    reset_n = 1'b0;
    #1;
    checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin errors++; $display("FAIL rst_mid_levels: got %0d %0d want 0 0", tx_level, rx_level); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_fifo_out: got %b %b %h want 1 0 00", in_ready, out_valid, out_data); end
    checks++; if (seq_busy !== 1'b0 || spi_start !== 1'b0 || spi_tx_data !== 8'h00 || err_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_fsm_out: got %b %b %h %b want 0 0 00 0", seq_busy, spi_start, spi_tx_data, err_timeout); end
    for (int i = 0; i < 50 && spi_busy; i++) @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL rst_mid_after: got %b %0d %0d want 1 0 0", in_ready, tx_level, rx_level); end
    checks++; if (start_cnt - s0 != 3) begin errors++; $display("FAIL rst_mid_no_launch: got %0d want 3", start_cnt - s0); end
  endtask

  task automatic test_clear();
    int s0; bit ok;
    busy_len = 20; s0 = start_cnt; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 8'h70 + 8'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = (start_cnt - s0 == 4); end
    repeat (5) @(negedge clk);
    checks++; if (!ok || rx_level !== 5'd3) begin errors++; $display("FAIL clr_setup: got starts %0d level %0d want 4 3", start_cnt - s0, rx_level); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin errors++; $display("FAIL clr_levels: got %0d %0d want 0 0", tx_level, rx_level); end
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL clr_gap: got seq_busy %b want 1", seq_busy); end
    for (int i = 0; i < 50 && spi_busy; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL clr_back_idle: got %b want 0", seq_busy); end
    checks++; if (rx_level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_late_rx: got level %0d valid %b want 0 0", rx_level, out_valid); end
    busy_len = 6;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_gap();
    test_reset_mid();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
